// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: load types, write-data selects,
// link offset and the packed W-stage register layout.
package wb_pkg;

  localparam logic [2:0] LDT_LW  = 3'b000;
  localparam logic [2:0] LDT_LB  = 3'b001;
  localparam logic [2:0] LDT_LBU = 3'b010;
  localparam logic [2:0] LDT_LH  = 3'b011;
  localparam logic [2:0] LDT_LHU = 3'b100;
  localparam logic [2:0] LDT_LWR = 3'b101;
  localparam logic [2:0] LDT_LWL = 3'b110;

  localparam logic [1:0] WDSEL_ALU = 2'b00;
  localparam logic [1:0] WDSEL_MEM = 2'b01;
  localparam logic [1:0] WDSEL_PC8 = 2'b10;

  localparam logic [31:0] PC_LINK_OFS = 32'd8;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  wa;
    logic [1:0]  wdsel;
    logic [2:0]  ldtype;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] old;
    logic [31:0] pc;
  } wb_regs_t;

endpackage

// File: rtl/load_ext.sv
// Load-data extender: byte/half lane selection with sign/zero extension.
// Optional lwl/lwr merge with the old rt value when WB_LWLR_EN is defined.
module load_ext
  import wb_pkg::*;
(
  input  logic [2:0]  ldtype_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] raw_i,
  input  logic [31:0] old_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = raw_i[{addr_i, 3'b000} +: 8];
  assign half_sel = addr_i[1] ? raw_i[31:16] : raw_i[15:0];

`ifndef WB_LWLR_EN
  logic unused_old;
  assign unused_old = ^old_i;
`endif

  always_comb begin
    data_o = raw_i;
    case (ldtype_i)
      LDT_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LDT_LBU: data_o = {24'h0, byte_sel};
      LDT_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      LDT_LHU: data_o = {16'h0, half_sel};
`ifdef WB_LWLR_EN
      LDT_LWL: begin
        case (addr_i)
          2'b00:   data_o = {raw_i[7:0], old_i[23:0]};
          2'b01:   data_o = {raw_i[15:0], old_i[15:0]};
          2'b10:   data_o = {raw_i[23:0], old_i[7:0]};
          default: data_o = raw_i;
        endcase
      end
      LDT_LWR: begin
        case (addr_i)
          2'b00:   data_o = raw_i;
          2'b01:   data_o = {old_i[31:24], raw_i[31:8]};
          2'b10:   data_o = {old_i[31:16], raw_i[31:16]};
          default: data_o = {old_i[31:8], raw_i[31:24]};
        endcase
      end
`endif
      // lw, reserved 111, and lwl/lwr when the merge is not built
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// M-to-W pipeline register, GRF write-port drive and retired-instruction counter.
// Define WB_LWLR_EN to register rtold and enable the lwl/lwr merge.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_M,
  input  logic [31:0]      pc_M,
  input  logic             we_M,
  input  logic [4:0]       wa_M,
  input  logic [1:0]       wdsel_M,
  input  logic [2:0]       ldtype_M,
  input  logic [DW-1:0]    alu_M,
  input  logic [DW-1:0]    dmrd_M,
  input  logic [DW-1:0]    rtold_M,
  output logic [4:0]       WA_W,
  output logic [DW-1:0]    WD_W,
  output logic             WE_W,
  output logic [31:0]      pc_W,
  output logic             valid_W,
  output logic [CNT_W-1:0] instret_W
);

  wb_regs_t         regs_d, regs_q;
  logic [CNT_W-1:0] instret_d, instret_q;
  logic [31:0]      ld_data;
  logic [31:0]      old_in;

`ifdef WB_LWLR_EN
  assign old_in = rtold_M;
`else
  logic unused_rtold;
  assign unused_rtold = ^rtold_M;
  assign old_in       = '0;
`endif

  // Flush beats stall; the instruction leaving W still retires on a flush.
  always_comb begin
    regs_d    = regs_q;
    instret_d = instret_q;
    if (flush) begin
      if (regs_q.valid) instret_d = instret_q + CNT_W'(1);
      regs_d.valid = 1'b0;
      regs_d.we    = 1'b0;
    end else if (!stall) begin
      if (regs_q.valid) instret_d = instret_q + CNT_W'(1);
      regs_d.valid  = valid_M;
      regs_d.we     = we_M;
      regs_d.wa     = wa_M;
      regs_d.wdsel  = wdsel_M;
      regs_d.ldtype = ldtype_M;
      regs_d.alu    = alu_M;
      regs_d.mem    = dmrd_M;
      regs_d.old    = old_in;
      regs_d.pc     = pc_M;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      regs_q    <= '0;
      instret_q <= '0;
    end else begin
      regs_q    <= regs_d;
      instret_q <= instret_d;
    end
  end

  load_ext u_load_ext (
    .ldtype_i (regs_q.ldtype),
    .addr_i   (regs_q.alu[1:0]),
    .raw_i    (regs_q.mem),
    .old_i    (regs_q.old),
    .data_o   (ld_data)
  );

  always_comb begin
    WD_W = regs_q.alu;
    case (regs_q.wdsel)
      WDSEL_MEM: WD_W = ld_data;
      WDSEL_PC8: WD_W = regs_q.pc + PC_LINK_OFS;
      default:   WD_W = regs_q.alu;
    endcase
  end

  // $0 is never written, so the hazard unit never forwards for it either.
  assign WE_W      = regs_q.valid & regs_q.we & (regs_q.wa != 5'd0);
  assign WA_W      = regs_q.wa;
  assign pc_W      = regs_q.pc;
  assign valid_W   = regs_q.valid;
  assign instret_W = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized traffic
// against a behavioural model of the W stage.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_M, we_M;
  logic [31:0] pc_M, alu_M, dmrd_M, rtold_M;
  logic [4:0]  wa_M;
  logic [1:0]  wdsel_M;
  logic [2:0]  ldtype_M;
  logic [4:0]  WA_W;
  logic [31:0] WD_W, pc_W, instret_W;
  logic        WE_W, valid_W;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of what W holds
  logic        m_valid, m_we;
  logic [4:0]  m_wa;
  logic [1:0]  m_wdsel;
  logic [2:0]  m_ldt;
  logic [31:0] m_alu, m_mem, m_old, m_pc, m_cnt;

  always #5 clk = ~clk;

  wb_stage #(.DW(32), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .valid_M   (valid_M),
    .pc_M      (pc_M),
    .we_M      (we_M),
    .wa_M      (wa_M),
    .wdsel_M   (wdsel_M),
    .ldtype_M  (ldtype_M),
    .alu_M     (alu_M),
    .dmrd_M    (dmrd_M),
    .rtold_M   (rtold_M),
    .WA_W      (WA_W),
    .WD_W      (WD_W),
    .WE_W      (WE_W),
    .pc_W      (pc_W),
    .valid_W   (valid_W),
    .instret_W (instret_W)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_wd();
    logic [31:0] ones = 32'hFFFF_FFFF;
    logic [31:0] v;
    int unsigned b = m_alu[1:0];
    if (m_wdsel == 2'b10) return m_pc + 32'd8;
    if (m_wdsel != 2'b01) return m_alu;
    case (m_ldt)
      3'd1: begin
        v = (m_mem >> (8 * b)) & 32'hFF;
        return v[7] ? (v | 32'hFFFF_FF00) : v;
      end
      3'd2: return (m_mem >> (8 * b)) & 32'hFF;
      3'd3: begin
        v = (m_mem >> (16 * m_alu[1])) & 32'hFFFF;
        return v[15] ? (v | 32'hFFFF_0000) : v;
      end
      3'd4: return (m_mem >> (16 * m_alu[1])) & 32'hFFFF;
`ifdef WB_LWLR_EN
      3'd6: return (m_mem << (8 * (3 - b))) | (m_old & (ones >> (8 * (b + 1))));
      3'd5: return (m_mem >> (8 * b)) | (m_old & ~(ones >> (8 * b)));
`endif
      default: return m_mem;
    endcase
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_valid = 0; m_we = 0; m_wa = 0; m_wdsel = 0; m_ldt = 0;
      m_alu = 0; m_mem = 0; m_old = 0; m_pc = 0; m_cnt = 0;
    end else if (flush) begin
      m_cnt   = m_cnt + 32'(m_valid);
      m_valid = 0;
      m_we    = 0;
    end else if (!stall) begin
      m_cnt   = m_cnt + 32'(m_valid);
      m_valid = valid_M; m_we = we_M; m_wa = wa_M; m_wdsel = wdsel_M; m_ldt = ldtype_M;
      m_alu = alu_M; m_mem = dmrd_M; m_old = rtold_M; m_pc = pc_M;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("valid_W", 32'(valid_W), 32'(m_valid));
    check_eq("WE_W", 32'(WE_W), 32'(m_valid && m_we && m_wa != 0));
    check_eq("instret_W", instret_W, m_cnt);
    if (m_valid) begin
      check_eq("WA_W", 32'(WA_W), 32'(m_wa));
      check_eq("WD_W", WD_W, model_wd());
      check_eq("pc_W", pc_W, m_pc);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] wa,
                       input logic [1:0] sel, input logic [2:0] ldt, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] old, input logic [31:0] pc);
    valid_M = v; we_M = we; wa_M = wa; wdsel_M = sel; ldtype_M = ldt;
    alu_M = alu; dmrd_M = mem; rtold_M = old; pc_M = pc;
  endtask

  logic [31:0] cnt_hold;

  initial begin
    reset = 0; stall = 0; flush = 0;
    drive(1, 1, 5'd3, WDSEL_ALU, LDT_LW, 32'h55, 32'h66, 32'h77, 32'h88);
    cycle();
    cycle();
    check_eq("rst_WA", 32'(WA_W), 32'h0);
    check_eq("rst_WD", WD_W, 32'h0);
    check_eq("rst_WE", 32'(WE_W), 32'h0);
    check_eq("rst_pc", pc_W, 32'h0);
    check_eq("rst_valid", 32'(valid_W), 32'h0);
    check_eq("rst_instret", instret_W, 32'h0);

    reset = 1;
    drive(1, 1, 5'd5, WDSEL_ALU, LDT_LW, 32'h1234, 32'h0, 32'h0, 32'h400);
    cycle();
    check_eq("alu_WA", 32'(WA_W), 32'd5);
    check_eq("alu_WD", WD_W, 32'h0000_1234);
    check_eq("alu_WE", 32'(WE_W), 32'd1);
    check_eq("alu_cnt0", instret_W, 32'd0);
    drive(0, 0, 5'd0, WDSEL_ALU, LDT_LW, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle();
    check_eq("alu_cnt1", instret_W, 32'd1);

    drive(1, 1, 5'd8, WDSEL_MEM, LDT_LB, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h404);
    cycle();
    check_eq("lb_b3", WD_W, 32'hFFFF_FF80);
    drive(1, 1, 5'd8, WDSEL_MEM, LDT_LBU, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h408);
    cycle();
    check_eq("lbu_b3", WD_W, 32'h0000_0080);
    drive(1, 1, 5'd8, WDSEL_MEM, LDT_LH, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h40C);
    cycle();
    check_eq("lh_b2", WD_W, 32'hFFFF_80FF);
    drive(1, 1, 5'd8, WDSEL_MEM, LDT_LHU, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 32'h410);
    cycle();
    check_eq("lhu_b0", WD_W, 32'h0000_7F01);

    drive(1, 1, 5'd31, WDSEL_PC8, LDT_LW, 32'h0, 32'h0, 32'h0, 32'h0000_3000);
    cycle();
    check_eq("link_wd", WD_W, 32'h0000_3008);
    drive(1, 1, 5'd0, WDSEL_ALU, LDT_LW, 32'hDEAD, 32'h0, 32'h0, 32'h414);
    cycle();
    check_eq("r0_we", 32'(WE_W), 32'd0);

    drive(1, 1, 5'd7, WDSEL_ALU, LDT_LW, 32'hA5A5_0007, 32'h0, 32'h0, 32'h418);
    cycle();
    cnt_hold = instret_W;
    stall = 1;
    drive(1, 1, 5'd9, WDSEL_ALU, LDT_LW, 32'h9999, 32'h0, 32'h0, 32'h41C);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("stall_WA", 32'(WA_W), 32'd7);
      check_eq("stall_WD", WD_W, 32'hA5A5_0007);
      check_eq("stall_WE", 32'(WE_W), 32'd1);
      check_eq("stall_cnt", instret_W, cnt_hold);
    end
    flush = 1;
    cycle();
    check_eq("flush_valid", 32'(valid_W), 32'd0);
    check_eq("flush_we", 32'(WE_W), 32'd0);
    check_eq("flush_cnt", instret_W, cnt_hold + 32'd1);
    flush = 0; stall = 0;

    drive(1, 1, 5'd4, WDSEL_MEM, LDT_LWL, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD, 32'h420);
    cycle();
`ifdef WB_LWLR_EN
    check_eq("lwl_b1", WD_W, 32'h3344_CCDD);
`else
    check_eq("lwl_b1", WD_W, 32'h1122_3344);
`endif
    drive(1, 1, 5'd4, WDSEL_MEM, LDT_LWR, 32'h0000_2002, 32'h1122_3344, 32'hAABB_CCDD, 32'h424);
    cycle();
`ifdef WB_LWLR_EN
    check_eq("lwr_b2", WD_W, 32'hAABB_1122);
`else
    check_eq("lwr_b2", WD_W, 32'h1122_3344);
`endif

    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 63) != 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom),
            2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
